// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if: start/busy/done handshake and operand/result bus; ovf present with SEQ_CHUNK_ADDER_OVF_EN
interface seq_chunk_adder_if #(parameter int WIDTH = 16);
  logic start, cin, sub, busy, done, cout;
  logic [WIDTH-1:0] a, b, sum;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic ovf;
`endif
  modport master (
    output start, a, b, cin, sub,
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    input ovf,
`endif
    input busy, done, sum, cout
  );
  modport slave (
    input start, a, b, cin, sub,
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/sub, CHUNK bits per clock LSB first; SEQ_CHUNK_ADDER_OVF_EN adds registered ovf
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] op_a, op_b, res, res_n;
  logic [IW-1:0] idx;
  logic [CHUNK:0] part;
  logic carry, accept, last;
  assign accept = bus.start && state != RUN;
  assign last = idx == IW'(NCHUNK - 1);
  assign part = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
  // new chunk enters at the top so the LSB chunk ends up at bit 0 after NCHUNK shifts
  assign res_n = WIDTH'({part[CHUNK-1:0], res} >> CHUNK);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
  end
  always_comb begin
    bus.busy = state == RUN;
    bus.done = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
      carry <= 1'b0;
      idx <= '0;
      res <= '0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      bus.ovf <= 1'b0;
`endif
    end else if (accept) begin
      op_a <= bus.a;
      op_b <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.cin ^ bus.sub;
      idx <= '0;
    end else if (state == RUN) begin
      op_a <= op_a >> CHUNK;
      op_b <= op_b >> CHUNK;
      carry <= part[CHUNK];
      idx <= idx + 1'b1;
      res <= res_n;
      if (last) begin
        bus.sum <= res_n;
        bus.cout <= part[CHUNK];
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        // a^b^s at the MSB recovers the carry into it
        bus.ovf <= op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ part[CHUNK-1] ^ part[CHUNK];
`endif
      end
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed vectors checked against an arithmetic reference model and literals
module tb_seq_chunk_adder;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  seq_chunk_adder_if #(.WIDTH(WIDTH)) bus ();
  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] calc(input logic [15:0] a, b, input logic cin, sub);
    int sa, sb, s;
    logic [16:0] u;
    logic [15:0] sm;
    logic co;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      u = 17'(a) + 17'(b) + 17'(cin);
      sm = u[15:0];
      co = u[16];
      s = sa + sb + int'(cin);
    end else begin
      sm = a - b - 16'(cin);
      co = 17'(a) >= 17'(b) + 17'(cin);
      s = sa - sb - int'(cin);
    end
    return {s > 32767 || s < -32768, co, sm};
  endfunction

  logic m_run, m_done, m_cout, m_ovf;
  logic [15:0] m_sum;
  logic [17:0] pend;
  int m_cnt;
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_run <= 1'b0;
      m_cnt <= 0;
      m_sum <= '0;
      m_cout <= 1'b0;
      m_ovf <= 1'b0;
    end else if (m_run) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_run <= 1'b0;
        m_done <= 1'b1;
        {m_ovf, m_cout, m_sum} <= pend;
      end
    end else if (bus.start) begin
      m_run <= 1'b1;
      m_cnt <= NCHUNK;
      pend <= calc(bus.a, bus.b, bus.cin, bus.sub);
    end
  end

  always @(negedge clk)
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_run));
      check("done", 32'(bus.done), 32'(m_done));
      check("sum", 32'(bus.sum), 32'(m_sum));
      check("cout", 32'(bus.cout), 32'(m_cout));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      check("ovf", 32'(bus.ovf), 32'(m_ovf));
`endif
    end

  task automatic wait_done(input bit glitch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
      if (glitch && n == 2) begin
        bus.start = 1'b1;
        bus.a = 16'hAAAA;
      end
    end while (!bus.done && n < 20);
  endtask

  task automatic run_op(input string nm, input logic [15:0] a, b, input logic cin, sub,
                        input logic [15:0] es, input logic ec, eo, input bit glitch);
    int n;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.sub = sub;
    bus.start = 1'b1;
    wait_done(glitch, n);
    check({nm, "_lat"}, 32'(n), 32'(NCHUNK + 1));
    check({nm, "_sum"}, 32'(bus.sum), 32'(es));
    check({nm, "_cout"}, 32'(bus.cout), 32'(ec));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    check({nm, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unused");
`endif
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_sum", 32'(bus.sum), 0);
    check("rst_cout", 32'(bus.cout), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_hold", 32'(bus.sum), 0);
    run_op("sub1", 16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0);
    run_op("sub2", 16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op("sub_cin", 16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    run_op("ignore", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);
    nd = 0;
    repeat (NCHUNK + 2) begin
      @(negedge clk);
      nd += int'(bus.done);
    end
    check("ignore_one_done", 32'(nd), 0);
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_sum", 32'(bus.sum), 0);
    check("abort_cout", 32'(bus.cout), 0);
    rst = 1'b0;
    nd = 0;
    repeat (2 * NCHUNK) begin
      @(negedge clk);
      nd += int'(bus.done);
    end
    check("abort_no_done", 32'(nd), 0);
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("b2b", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    run_op("b2b_neg", 16'hFFFE, 16'hFFFE, 1'b1, 1'b0, 16'hFFFD, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
